par_to_serial_tx: RTL

- Downstream neighbour of the PHY TX byte multiplexer. Consumes the 8-bit byte stream data_000/valid_000, which is held stable for 8 cycles of clk_32f.
- Serializes each byte MSB-first onto a single line at clk_32f.
- Transmits the K28.5 comma (8'hBC) whenever no valid byte is available.
- After reset, sends a fixed preamble of comma bytes so the receiver can lock before payload is sent.

---
 rtl/par_to_serial_tx.sv | 63 ++++++
 1 files changed

// File: rtl/par_to_serial_tx.sv
// par_to_serial_tx: MSB-first byte serializer with K28.5 comma idle fill and post-reset sync preamble
module par_to_serial_tx #(
    parameter int         SYNC_BYTES = 4,
    parameter logic [7:0] COMMA      = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_000,
    input  logic       valid_000,
    output logic       data_out,
    output logic       byte_load,
    output logic       payload,
    output logic       active
);
    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     state_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sync_cnt_q;
    logic [7:0] shreg_q, byte_d;
    logic       load, from_data, sync_done;

    // Byte selection: commas during the preamble, otherwise the input byte when qualified
    always_comb begin
        load      = bit_cnt_q == 3'd0;
        from_data = state_q == ACTIVE && valid_000;
        byte_d    = from_data ? data_000 : COMMA;
        bit_cnt_d = bit_cnt_q + 3'd1;
        sync_done = sync_cnt_q == 4'(SYNC_BYTES - 1);
    end

    // Serializer datapath and SYNC/ACTIVE control with registered outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= SYNC;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            shreg_q    <= '0;
            data_out   <= 1'b0;
            byte_load  <= 1'b0;
            payload    <= 1'b0;
            active     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            if (load) begin
                data_out  <= byte_d[7];
                shreg_q   <= {byte_d[6:0], 1'b0};
                byte_load <= 1'b1;
                payload   <= from_data;
                if (state_q == SYNC) begin
                    sync_cnt_q <= sync_done ? 4'd0 : sync_cnt_q + 4'd1;
                    if (sync_done) state_q <= ACTIVE;
                end else begin
                    active <= 1'b1;
                end
            end else begin
                data_out  <= shreg_q[7];
                shreg_q   <= {shreg_q[6:0], 1'b0};
                byte_load <= 1'b0;
            end
        end
    end
endmodule
